vga_timing: RTL and testbench

- Free-running VGA raster timing generator.
- Produces horizontal/vertical counters, sync pulses and blanking flags.
- Sits directly upstream of the pixel-pipeline delay/draw stages; its outputs feed their vcount_in/vsync_in/vblnk_in/hcount_in/hsync_in/hblnk_in inputs unchanged.
- Default timing is 800x600@60 Hz at a 40 MHz pixel clock.

---
 rtl/vga_timing.sv | 98 +++++++++
 tb/tb_vga_timing.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator (800x600@60 by default).
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int SYNC_POS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    output logic [10:0] vcount,
    output logic        vsync,
    output logic        vblnk,
    output logic [10:0] hcount,
    output logic        hsync,
    output logic        hblnk,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
`endif
    output logic        frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOT > 2048 || V_TOT > 2048) begin : g_width_check
        $fatal(1, "vga_timing: H_TOT/V_TOT exceed 11-bit counters");
    end

    localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOT - 1);
    localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        S_ON   = (SYNC_POS != 0);

    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        h_wrap;
    logic        hs_act;
    logic        vs_act;
    logic        wrap_00;

    // Flags derive from next counts so they register alongside them.
    always_comb begin
        h_wrap  = (hcount == H_LAST);
        h_next  = h_wrap ? 11'd0 : hcount + 11'd1;
        v_next  = vcount;
        if (h_wrap) begin
            v_next = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
        end
        hs_act  = (h_next >= HS_BEG) && (h_next < HS_END);
        vs_act  = (v_next >= VS_BEG) && (v_next < VS_END);
        wrap_00 = (h_next == 11'd0) && (v_next == 11'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hcount      <= '0;
            vcount      <= '0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            hsync       <= ~S_ON;
            vsync       <= ~S_ON;
            frame_start <= 1'b0;
        end else if (ce) begin
            hcount      <= h_next;
            vcount      <= v_next;
            hblnk       <= (h_next >= H_VIS);
            vblnk       <= (v_next >= V_VIS);
            hsync       <= hs_act ? S_ON : ~S_ON;
            vsync       <= vs_act ? S_ON : ~S_ON;
            frame_start <= wrap_00;
        end else begin
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (ce && wrap_00) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing using a reduced raster for short runs.
// Expected values come from an enabled-cycle counter decomposed into h/v.
module tb_vga_timing;

    localparam int HA = 16;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 4;
    localparam int VA = 12;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic        frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    int          t = 0;
    int          cyc = 0;
    logic [15:0] fc = '0;
    exp_t        sb[$];

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POS(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .vcount(vcount),
        .vsync(vsync),
        .vblnk(vblnk),
        .hcount(hcount),
        .hsync(hsync),
        .hblnk(hblnk),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic c);
        exp_t e;
        int   h;
        int   v;
        rst = r;
        ce  = c;
        e.fs = 1'b0;
        if (!r) begin
            t  = 0;
            fc = '0;
        end else if (c) begin
            t++;
            if (t % FRAME == 0) begin
                e.fs = 1'b1;
                fc++;
            end
        end
        h = t % HT;
        v = (t / HT) % VT;
        e.h  = 11'(h);
        e.v  = 11'(v);
        e.hb = (h >= HA);
        e.vb = (v >= VA);
        e.hs = (h >= HA + HF) && (h < HA + HF + HS);
        e.vs = (v >= VA + VF) && (v < VA + VF + VS);
        e.fc = fc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        check("hcount", 16'(hcount), 16'(e.h));
        check("vcount", 16'(vcount), 16'(e.v));
        check("hsync", 16'(hsync), 16'(e.hs));
        check("vsync", 16'(vsync), 16'(e.vs));
        check("hblnk", 16'(hblnk), 16'(e.hb));
        check("vblnk", 16'(vblnk), 16'(e.vb));
        check("frame_start", 16'(frame_start), 16'(e.fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("frame_cnt", frame_cnt, e.fc);
`endif
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2 * FRAME && (t % FRAME) != target; i++) begin
            step(1'b1, 1'b1);
        end
        check("run_to", 16'(t % FRAME), 16'(target));
    endtask

    initial begin
        int hw;
        int vw;
        int last;
        int np;
        hw = 0;
        vw = 0;
        last = -1;
        np = 0;

        repeat (5) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("first_h", 16'(hcount), 16'd1);

        // Two full frames: line and frame boundaries, pulse spacing
        for (int i = 0; i < 2 * FRAME + 40; i++) begin
            step(1'b1, 1'b1);
            if (hsync && t >= HT && t < 2 * HT) hw++;
            if (vsync && t < FRAME) vw++;
            if (frame_start) begin
                np++;
                if (last >= 0) check("fs_gap", 16'(cyc - last), 16'(FRAME));
                last = cyc;
            end
        end
        check("hsync_width", 16'(hw), 16'(HS));
        check("vsync_cycles", 16'(vw), 16'(VS * HT));
        check("fs_pulses", 16'(np), 16'd2);

        // Clock-enable freeze mid-frame
        run_to(6 * HT + 10);
        repeat (10) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("resume_h", 16'(hcount), 16'd11);

        // Drop ce right at the frame wrap
        run_to(FRAME - 1);
        step(1'b1, 1'b1);
        check("fs_at_wrap", 16'(frame_start), 16'd1);
        repeat (4) step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // Reset in the middle of hsync and vsync
        run_to((VA + VF + 1) * HT + HA + HF + 2);
        check("mid_hsync_on", 16'(hsync), 16'd1);
        check("mid_vsync_on", 16'(vsync), 16'd1);
        step(1'b0, 1'b1);
        check("rst_hsync", 16'(hsync), 16'd0);
        check("rst_vsync", 16'(vsync), 16'd0);
        step(1'b1, 1'b1);

`ifdef VGA_TIMING_FRAME_CNT_EN
        for (int i = 0; i < 3 * FRAME; i++) step(1'b1, 1'b1);
        check("fc_3frames", frame_cnt, 16'd3);
        run_to(FRAME - 2);
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        fc = 16'hFFFF;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("fc_wrap", frame_cnt, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
